mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose
//   Two-requester arbiter in front of a single-port memory. A request is
//   accepted only while the arbiter is idle; ties are resolved round-robin
//   against the requester that completed last. The accepted request is replayed
//   to the memory as a one-cycle strobe, the arbiter then waits for the memory's
//   ready (or a timeout), and finally returns a one-cycle ack, with read data
//   and an error flag, to the requester that was granted.
//
// Ports
//   clk_i, rst_i            clock (rising edge) / asynchronous active-low reset
//   reqN_valid_i            requester N has a pending request (N = 0, 1)
//   reqN_wr_rd_en_i         1 = write, 0 = read
//   reqN_addr_i/_wdata_i    request address / write data
//   reqN_ack_o              one-cycle completion pulse
//   reqN_rdata_o/_err_o     read data / timeout flag, valid only with ack
//   mem_valid_o             one-cycle memory request strobe
//   mem_wr_rd_en_o          memory direction, 1 = write
//   mem_addr_o/_wdata_o     memory address / write data (held until next grant)
//   mem_ready_i             memory completion strobe
//   mem_rdata_i             memory read data, valid with mem_ready_i
//   busy_o                  1 whenever a transaction is in flight
//   grant_o                 requester currently or most recently served
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_valid_i,
    input  logic              req0_wr_rd_en_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    output logic              req0_ack_o,
    output logic [DATA_W-1:0] req0_rdata_o,
    output logic              req0_err_o,

    input  logic              req1_valid_i,
    input  logic              req1_wr_rd_en_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    output logic              req1_ack_o,
    output logic [DATA_W-1:0] req1_rdata_o,
    output logic              req1_err_o,

    output logic              mem_valid_o,
    output logic              mem_wr_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              busy_o,
    output logic              grant_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Last WAIT-cycle count before giving up; counter is 8 bits wide so the
    // full 1..255 timeout range fits.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [7:0]        r_cnt;
    logic              r_last_grant;
    logic              r_grant;
    logic              r_busy;
    logic              r_mem_valid;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [1:0]        r_ack;
    logic [1:0]        r_err;
    logic [DATA_W-1:0] r_rdata [2];

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t            w_state_next;
    logic [7:0]        w_cnt_next;
    logic              w_last_grant_next;
    logic              w_grant_next;
    logic              w_busy_next;
    logic              w_mem_valid_next;
    logic              w_mem_wr_next;
    logic [ADDR_W-1:0] w_mem_addr_next;
    logic [DATA_W-1:0] w_mem_wdata_next;
    logic [1:0]        w_ack_next;
    logic [1:0]        w_err_next;
    logic [DATA_W-1:0] w_rdata_next [2];

    // Arbitration decision, only meaningful in IDLE.
    logic              w_any_valid;
    logic              w_pick;

    assign w_any_valid = req0_valid_i | req1_valid_i;
    // Tie goes to whoever was not served last; otherwise the lone requester.
    assign w_pick      = (req0_valid_i & req1_valid_i) ? ~r_last_grant : req1_valid_i;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_last_grant_next = r_last_grant;
        w_grant_next      = r_grant;
        w_mem_valid_next  = 1'b0;
        w_mem_wr_next     = r_mem_wr;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;
        // Completion outputs are nonzero only while in DONE: they are loaded
        // on the WAIT->DONE transition and fall back to zero on every other
        // edge, which also clears them when DONE exits.
        w_ack_next        = 2'b00;
        w_err_next        = 2'b00;
        w_rdata_next[0]   = '0;
        w_rdata_next[1]   = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_grant_next     = w_pick;
                    w_mem_wr_next    = w_pick ? req1_wr_rd_en_i : req0_wr_rd_en_i;
                    w_mem_addr_next  = w_pick ? req1_addr_i     : req0_addr_i;
                    w_mem_wdata_next = w_pick ? req1_wdata_i    : req0_wdata_i;
                    w_mem_valid_next = 1'b1;
                    w_state_next     = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                w_cnt_next   = '0;
                w_state_next = ST_WAIT;
            end

            ST_WAIT: begin
                w_cnt_next = r_cnt + 8'd1;
                // Ready is tested first so it wins over a coincident timeout.
                if (mem_ready_i) begin
                    w_state_next          = ST_DONE;
                    w_ack_next[r_grant]   = 1'b1;
                    w_rdata_next[r_grant] = r_mem_wr ? '0 : mem_rdata_i;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next        = ST_DONE;
                    w_ack_next[r_grant] = 1'b1;
                    w_err_next[r_grant] = 1'b1;
                end
            end

            ST_DONE: begin
                w_last_grant_next = r_grant;
                w_state_next      = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_busy_next = (w_state_next != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            // Pretend requester 1 went last so requester 0 wins the first tie.
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_ack        <= 2'b00;
            r_err        <= 2'b00;
            r_rdata[0]   <= '0;
            r_rdata[1]   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_last_grant <= w_last_grant_next;
            r_grant      <= w_grant_next;
            r_busy       <= w_busy_next;
            r_mem_valid  <= w_mem_valid_next;
            r_mem_wr     <= w_mem_wr_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_ack        <= w_ack_next;
            r_err        <= w_err_next;
            r_rdata[0]   <= w_rdata_next[0];
            r_rdata[1]   <= w_rdata_next[1];
        end
    end

    // ------------------------------------------------------------------
    // Output mapping (all driven straight from registers)
    // ------------------------------------------------------------------
    assign req0_ack_o     = r_ack[0];
    assign req0_err_o     = r_err[0];
    assign req0_rdata_o   = r_rdata[0];
    assign req1_ack_o     = r_ack[1];
    assign req1_err_o     = r_err[1];
    assign req1_rdata_o   = r_rdata[1];

    assign mem_valid_o    = r_mem_valid;
    assign mem_wr_rd_en_o = r_mem_wr;
    assign mem_addr_o     = r_mem_addr;
    assign mem_wdata_o    = r_mem_wdata;

    assign busy_o         = r_busy;
    assign grant_o        = r_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose
//   Self-checking bench for mem_arbiter. A transaction-level reference model
//   predicts, at every grant edge, who is served, when the ack appears and
//   what it carries; a per-cycle monitor compares the DUT against it. Directed
//   scenarios cover write/read, tie-breaking, back-to-back contention, timeout
//   boundaries, reset mid-transaction and input perturbation, followed by a
//   randomized run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req0_valid_i, req0_wr_rd_en_i;
    logic [AW-1:0] req0_addr_i;
    logic [DW-1:0] req0_wdata_i;
    logic          req0_ack_o, req0_err_o;
    logic [DW-1:0] req0_rdata_o;
    logic          req1_valid_i, req1_wr_rd_en_i;
    logic [AW-1:0] req1_addr_i;
    logic [DW-1:0] req1_wdata_i;
    logic          req1_ack_o, req1_err_o;
    logic [DW-1:0] req1_rdata_o;
    logic          mem_valid_o, mem_wr_rd_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ready_i;
    logic [DW-1:0] mem_rdata_i;
    logic          busy_o, grant_o;

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_wr_rd_en_i(req0_wr_rd_en_i),
        .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
        .req0_ack_o(req0_ack_o), .req0_rdata_o(req0_rdata_o), .req0_err_o(req0_err_o),
        .req1_valid_i(req1_valid_i), .req1_wr_rd_en_i(req1_wr_rd_en_i),
        .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
        .req1_ack_o(req1_ack_o), .req1_rdata_o(req1_rdata_o), .req1_err_o(req1_err_o),
        .mem_valid_o(mem_valid_o), .mem_wr_rd_en_o(mem_wr_rd_en_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Every DUT output folded into one vector; all-zero means "reset-like".
    function automatic logic [31:0] outs_vec();
        return {20'd0, req0_ack_o, req1_ack_o, req0_err_o, req1_err_o,
                mem_valid_o, mem_wr_rd_en_o, busy_o, grant_o,
                |req0_rdata_o, |req1_rdata_o, |mem_addr_o, |mem_wdata_o};
    endfunction

    // ------------------------------------------------------------------
    // Memory responder: ready arrives in the mem_lat-th WAIT cycle
    // (mem_lat = 0 means never). Off-cycle and write-completion data is
    // random garbage so the DUT is seen to ignore it.
    // ------------------------------------------------------------------
    int            mem_lat = 1;
    logic [DW-1:0] marr [64];
    int            m_cnt = 0;
    bit            m_wr;
    logic [AW-1:0] m_addr;

    initial begin
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ready_i = 1'b0;
            mem_rdata_i = DW'($urandom);
            if (!rst_i) begin
                m_cnt = 0;
            end else begin
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        mem_ready_i = 1'b1;
                        if (!m_wr) mem_rdata_i = marr[m_addr];
                    end
                end
                if (mem_valid_o) begin
                    if (mem_wr_rd_en_o) marr[mem_addr_o] = mem_wdata_o;
                    m_wr   = mem_wr_rd_en_o;
                    m_addr = mem_addr_o;
                    m_cnt  = mem_lat;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model (transaction level). At an edge where the arbiter is
    // free and someone is valid, decide the winner and compute the whole
    // outcome: k WAIT cycles, ack visible k+1 cycles after the grant edge,
    // free again k+3 edges after it.
    // ------------------------------------------------------------------
    typedef struct {
        int            s;
        bit            g;
        logic [DW-1:0] rd;
        bit            er;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [64];
    int            cyc = 0;
    bit            m_last = 1'b1;
    bit            m_have = 1'b0;
    int            m_gs, m_k, m_next_idle = 0;
    bit            m_g, m_gwr;
    logic [AW-1:0] m_gaddr;
    logic [DW-1:0] m_gwdata;

    always @(posedge clk_i) begin
        exp_t e;
        bit   timeout;
        cyc++;
        if (!rst_i) begin
            m_last      = 1'b1;
            m_have      = 1'b0;
            m_next_idle = 0;
            exp_q.delete();
        end else if (cyc >= m_next_idle && (req0_valid_i || req1_valid_i)) begin
            m_g      = (req0_valid_i && req1_valid_i) ? !m_last : req1_valid_i;
            m_gwr    = m_g ? req1_wr_rd_en_i : req0_wr_rd_en_i;
            m_gaddr  = m_g ? req1_addr_i     : req0_addr_i;
            m_gwdata = m_g ? req1_wdata_i    : req0_wdata_i;
            timeout  = (mem_lat == 0) || (mem_lat > TO);
            m_k      = timeout ? TO : mem_lat;
            e.s      = cyc + m_k + 1;
            e.g      = m_g;
            e.er     = timeout;
            e.rd     = (timeout || m_gwr) ? '0 : ref_mem[m_gaddr];
            if (m_gwr) ref_mem[m_gaddr] = m_gwdata;
            exp_q.push_back(e);
            m_gs        = cyc;
            m_next_idle = cyc + m_k + 3;
            m_last      = m_g;
            m_have      = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle monitor (mid-cycle sampling)
    // ------------------------------------------------------------------
    int mv_cnt = 0;

    always @(negedge clk_i) begin
        exp_t e;
        if (mem_valid_o) mv_cnt++;
        if (!rst_i) begin
            chk("rst_outs", outs_vec(), 32'd0);
        end else begin
            if (exp_q.size() > 0 && exp_q[0].s == cyc) begin
                e = exp_q.pop_front();
                chk("ack_vec", {30'd0, req1_ack_o, req0_ack_o}, e.g ? 32'd2 : 32'd1);
                chk("ack_rdata", e.g ? req1_rdata_o : req0_rdata_o, {16'd0, e.rd});
                chk("ack_err", e.g ? req1_err_o : req0_err_o, {31'd0, e.er});
                chk("ack_other_zero", e.g ? {15'd0, req0_err_o, req0_rdata_o}
                                          : {15'd0, req1_err_o, req1_rdata_o}, 32'd0);
                chk("ack_grant", grant_o, {31'd0, e.g});
            end else begin
                chk("no_ack", {26'd0, req0_ack_o, req1_ack_o, req0_err_o, req1_err_o,
                               |req0_rdata_o, |req1_rdata_o}, 32'd0);
            end
            if (m_have) begin
                chk("mem_valid", mem_valid_o, {31'd0, cyc == m_gs});
                chk("busy", busy_o, {31'd0, (cyc >= m_gs) && (cyc <= m_gs + m_k + 1)});
                chk("mem_fields", {9'd0, mem_wr_rd_en_o, mem_addr_o, mem_wdata_o},
                                  {9'd0, m_gwr, m_gaddr, m_gwdata});
                chk("grant", grant_o, {31'd0, m_g});
            end else begin
                chk("idle_outs", {29'd0, mem_valid_o, busy_o, grant_o}, 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Requester driving
    // ------------------------------------------------------------------
    bit grant_log[$];

    task automatic set_req(input bit r, input bit v, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (r) begin
            req1_valid_i = v; req1_wr_rd_en_i = wr; req1_addr_i = a; req1_wdata_i = d;
        end else begin
            req0_valid_i = v; req0_wr_rd_en_i = wr; req0_addr_i = a; req0_wdata_i = d;
        end
    endtask

    // Issue one request from requester r (caller is at a negedge), hold it
    // until ack, drop valid in the ack cycle. lat counts negedges from the
    // valid being raised to the ack being seen.
    task automatic req_txn(input bit r, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit perturb,
                           output logic [DW-1:0] rd, output bit er, output int lat);
        int n   = 0;
        bit got = 1'b0;
        rd = '0;
        er = 1'b0;
        set_req(r, 1'b1, wr, a, d);
        while (!got && n < 40) begin
            @(negedge clk_i);
            n++;
            if (perturb && n == 2) begin
                set_req(r, 1'b1, wr, ~a, DW'($urandom));
                chk("perturb_addr_hold", {26'd0, mem_addr_o}, {26'd0, a});
            end
            if ((r ? req1_ack_o : req0_ack_o) === 1'b1) begin
                got = 1'b1;
                rd  = r ? req1_rdata_o : req0_rdata_o;
                er  = r ? req1_err_o : req0_err_o;
                grant_log.push_back(r);
            end
        end
        chk("ack_seen", {31'd0, got}, 32'd1);
        lat = n;
        set_req(r, 1'b0, 1'b0, '0, '0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    logic [DW-1:0] rd0, rd1;
    bit            er0, er1;
    int            lat0, lat1;
    logic [AW-1:0] ta0, ta1;
    int            done_cnt, guard;
    bit            vr, ar, any_ack;

    initial begin
        rst_i = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 64; i++) begin
            rd0        = DW'($urandom);
            ref_mem[i] = rd0;
            marr[i]    = rd0;
        end
        #1;
        chk("reset_state", outs_vec(), 32'd0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;

        // Simultaneous reads straight after reset: requester 0 first.
        ta0 = AW'($urandom);
        ta1 = AW'($urandom);
        grant_log.delete();
        fork
            req_txn(1'b0, 1'b0, ta0, '0, 1'b0, rd0, er0, lat0);
            req_txn(1'b1, 1'b0, ta1, '0, 1'b0, rd1, er1, lat1);
        join
        chk("tie_lat0", lat0, 32'd3);
        chk("tie_lat1", lat1, 32'd7);
        chk("tie_rd0", {16'd0, rd0}, {16'd0, ref_mem[ta0]});
        chk("tie_rd1", {16'd0, rd1}, {16'd0, ref_mem[ta1]});
        chk("tie_log_size", grant_log.size(), 32'd2);
        for (int i = 0; i < grant_log.size(); i++)
            chk("tie_order", {31'd0, grant_log[i]}, i);

        // Back-to-back contention, re-requesting in the ack cycle.
        grant_log.delete();
        fork
            begin
                logic [DW-1:0] t_rd; bit t_er; int t_lat;
                repeat (3) req_txn(1'b0, 1'($urandom), AW'($urandom), DW'($urandom), 1'b0, t_rd, t_er, t_lat);
            end
            begin
                logic [DW-1:0] t_rd; bit t_er; int t_lat;
                repeat (3) req_txn(1'b1, 1'($urandom), AW'($urandom), DW'($urandom), 1'b0, t_rd, t_er, t_lat);
            end
        join
        chk("b2b_count", grant_log.size(), 32'd6);
        for (int i = 0; i < grant_log.size(); i++)
            chk("b2b_alternate", {31'd0, grant_log[i]}, i % 2);

        // Write then read back at address 5.
        repeat (2) @(negedge clk_i);
        req_txn(1'b0, 1'b1, 6'd5, 16'hA5A5, 1'b0, rd0, er0, lat0);
        chk("wr_rdata_zero", {16'd0, rd0}, 32'd0);
        chk("wr_err", {31'd0, er0}, 32'd0);
        chk("wr_lat", lat0, 32'd3);
        repeat (2) @(negedge clk_i);
        req_txn(1'b0, 1'b0, 6'd5, 16'h0000, 1'b0, rd0, er0, lat0);
        chk("rd_data", {16'd0, rd0}, 32'h0000A5A5);
        chk("rd_err", {31'd0, er0}, 32'd0);
        chk("rd_lat", lat0, 32'd3);

        // Timeout: memory never answers.
        repeat (2) @(negedge clk_i);
        mem_lat = 0;
        mv_cnt  = 0;
        req_txn(1'b1, 1'b0, 6'd9, '0, 1'b0, rd1, er1, lat1);
        chk("to_err", {31'd0, er1}, 32'd1);
        chk("to_rdata", {16'd0, rd1}, 32'd0);
        chk("to_lat", lat1, TO + 2);
        chk("to_single_strobe", mv_cnt, 32'd1);

        // Ready in the last WAIT cycle wins; one cycle later times out.
        repeat (2) @(negedge clk_i);
        mem_lat = TO;
        req_txn(1'b1, 1'b0, 6'd5, '0, 1'b0, rd1, er1, lat1);
        chk("edge_ready_err", {31'd0, er1}, 32'd0);
        chk("edge_ready_data", {16'd0, rd1}, 32'h0000A5A5);
        chk("edge_ready_lat", lat1, TO + 2);
        repeat (2) @(negedge clk_i);
        mem_lat = TO + 1;
        req_txn(1'b0, 1'b0, 6'd5, '0, 1'b0, rd0, er0, lat0);
        chk("late_ready_err", {31'd0, er0}, 32'd1);
        chk("late_ready_lat", lat0, TO + 2);

        // Address perturbation while waiting on memory.
        repeat (2) @(negedge clk_i);
        mem_lat = 3;
        req_txn(1'b0, 1'b1, 6'd12, 16'h1234, 1'b0, rd0, er0, lat0);
        repeat (2) @(negedge clk_i);
        req_txn(1'b1, 1'b1, 6'd51, 16'hBEEF, 1'b0, rd1, er1, lat1);
        repeat (2) @(negedge clk_i);
        req_txn(1'b0, 1'b0, 6'd12, '0, 1'b1, rd0, er0, lat0);
        chk("perturb_data", {16'd0, rd0}, 32'h00001234);
        chk("perturb_lat", lat0, 32'd5);

        // Reset in the middle of WAIT.
        repeat (2) @(negedge clk_i);
        mem_lat = 0;
        set_req(1'b0, 1'b1, 1'b0, 6'd7, '0);
        repeat (3) @(negedge clk_i);
        chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        #1 rst_i = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("rst_async_outs", outs_vec(), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i   = 1'b1;
        mem_lat = 1;
        req_txn(1'b1, 1'b0, 6'd12, '0, 1'b0, rd1, er1, lat1);
        chk("post_rst_lat", lat1, 32'd3);
        chk("post_rst_data", {16'd0, rd1}, 32'h00001234);

        // Randomized traffic.
        done_cnt = 0;
        guard    = 0;
        while (done_cnt < 150 && guard < 4000) begin
            @(negedge clk_i);
            guard++;
            any_ack = req0_ack_o | req1_ack_o;
            for (int r = 0; r < 2; r++) begin
                vr = (r == 1) ? req1_valid_i : req0_valid_i;
                ar = (r == 1) ? req1_ack_o : req0_ack_o;
                if (vr && ar) begin
                    done_cnt++;
                    if ($urandom_range(1, 0) == 1)
                        set_req(1'(r), 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
                    else
                        set_req(1'(r), 1'b0, 1'b0, '0, '0);
                end else if (!vr) begin
                    if ($urandom_range(2, 0) == 0)
                        set_req(1'(r), 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
                end else if (busy_o && !any_ack && (grant_o == 1'(r)) && $urandom_range(7, 0) == 0) begin
                    set_req(1'(r), 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
                end
            end
            if (any_ack) mem_lat = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(10, 1));
        end
        chk("rand_progress", {31'd0, done_cnt >= 150}, 32'd1);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (15) @(negedge clk_i);
        chk("exp_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
